// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: pixel position, polarity-configurable syncs,
// registered display_on, line/frame/vblank strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned CW       = 10,
    parameter int unsigned FCW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic [CW-1:0]  hpos,
    output logic [CW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start,
    output logic [FCW-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0]  hpos_q, hpos_d;
    logic [CW-1:0]  vpos_q, vpos_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic           ls_q, ls_d;
    logic           fs_q, fs_d;
    logic           vbs_q, vbs_d;

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        fc_d   = fc_q;
        if (pix_en) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                if (vpos_q == V_LAST) begin
                    vpos_d = '0;
                    fc_d   = fc_q + FCW'(1);
                end else begin
                    vpos_d = vpos_q + CW'(1);
                end
            end else begin
                hpos_d = hpos_q + CW'(1);
            end
        end

        // Decoded from next-state counters so outputs line up with hpos/vpos.
        hsync_d = ((hpos_d >= HS_BEG) && (hpos_d <= HS_END)) ? H_POL : ~H_POL;
        vsync_d = ((vpos_d >= VS_BEG) && (vpos_d <= VS_END)) ? V_POL : ~V_POL;
        de_d    = (hpos_d < H_ACT) && (vpos_d < V_ACT);

        ls_d  = pix_en && (hpos_d == '0);
        fs_d  = ls_d && (vpos_d == '0);
        vbs_d = ls_d && (vpos_d == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            fc_q    <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            fc_q    <= fc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = de_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default and small-timing instances checked every cycle
// against a count-of-enabled-edges model, plus directed literal expectations.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Default-timing instance
    logic       rst_d, en_d;
    logic [9:0] hpos_d, vpos_d;
    logic [7:0] fc_d;
    logic       hs_d, vs_d, de_d, ls_d, fs_d, vbs_d;

    vga_timing_gen dut_d (
        .clk(clk), .reset(rst_d), .pix_en(en_d),
        .hpos(hpos_d), .vpos(vpos_d), .hsync(hs_d), .vsync(vs_d),
        .display_on(de_d), .line_start(ls_d), .frame_start(fs_d),
        .vblank_start(vbs_d), .frame_count(fc_d)
    );

    // Small instance: 8x6 totals, active-high syncs, 2-bit frame counter
    logic       rst_s, en_s;
    logic [3:0] hpos_s, vpos_s;
    logic [1:0] fc_s;
    logic       hs_s, vs_s, de_s, ls_s, fs_s, vbs_s;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .pix_en(en_s),
        .hpos(hpos_s), .vpos(vpos_s), .hsync(hs_s), .vsync(vs_s),
        .display_on(de_s), .line_start(ls_s), .frame_start(fs_s),
        .vblank_start(vbs_s), .frame_count(fc_s)
    );

    // Model: the whole state is the number of enabled edges since reset.
    longint n_dm = 0, n_sm = 0;
    bit     enp_dm = 1'b0, enp_sm = 1'b0;
    bit     mok_dm = 1'b0, mok_sm = 1'b0;

    always @(posedge clk) begin
        if (rst_d) begin
            n_dm <= 0; enp_dm <= 1'b0; mok_dm <= 1'b1;
        end else begin
            if (en_d) n_dm <= n_dm + 1;
            enp_dm <= en_d;
        end
        if (rst_s) begin
            n_sm <= 0; enp_sm <= 1'b0; mok_sm <= 1'b1;
        end else begin
            if (en_s) n_sm <= n_sm + 1;
            enp_sm <= en_s;
        end
    end

    task automatic model(input longint n, input bit enp,
                         input longint ha, hf, hsy, hb, va, vf, vsy, vb,
                         input bit hp, vp, input longint fcw,
                         output longint h, v, fc,
                         output bit hs, vs, de, ls, fs, vbs);
        longint ht, vt;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        fc = (n / (ht * vt)) % (longint'(1) << fcw);
        hs = (h >= ha + hf && h < ha + hf + hsy) ? hp : !hp;
        vs = (v >= va + vf && v < va + vf + vsy) ? vp : !vp;
        de = (h < ha) && (v < va);
        ls = enp && (h == 0);
        fs = ls && (v == 0);
        vbs = ls && (v == va);
    endtask

    always @(negedge clk) begin
        longint h, v, fc;
        bit hs, vs, de, ls, fs, vbs;
        if (mok_dm && !rst_d) begin
            model(n_dm, enp_dm, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8,
                  h, v, fc, hs, vs, de, ls, fs, vbs);
            chk("d.hpos", hpos_d, h);  chk("d.vpos", vpos_d, v);
            chk("d.fc", fc_d, fc);     chk("d.hsync", hs_d, hs);
            chk("d.vsync", vs_d, vs);  chk("d.de", de_d, de);
            chk("d.ls", ls_d, ls);     chk("d.fs", fs_d, fs);
            chk("d.vbs", vbs_d, vbs);
        end
        if (mok_sm && !rst_s) begin
            model(n_sm, enp_sm, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2,
                  h, v, fc, hs, vs, de, ls, fs, vbs);
            chk("s.hpos", hpos_s, h);  chk("s.vpos", vpos_s, v);
            chk("s.fc", fc_s, fc);     chk("s.hsync", hs_s, hs);
            chk("s.vsync", vs_s, vs);  chk("s.de", de_s, de);
            chk("s.ls", ls_s, ls);     chk("s.fs", fs_s, fs);
            chk("s.vbs", vbs_s, vbs);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cnt_hs, hs_min, hs_max, cnt_de, cnt_ls, cnt_vs, cnt_vbs, nfs, adj;
        int t_first, t_second;
        int fcseq[5];
        bit prev_ls;

        rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
        repeat (3) step();
        rst_d = 1'b0; rst_s = 1'b0;
        step();
        // Reset state literals
        chk("rst.hpos", hpos_d, 0);   chk("rst.vpos", vpos_d, 0);
        chk("rst.hsync", hs_d, 1);    chk("rst.vsync", vs_d, 1);
        chk("rst.de", de_d, 1);       chk("rst.fc", fc_d, 0);
        chk("rst.ls", ls_d, 0);       chk("rst.s_hsync", hs_s, 0);

        // One default line: hsync window and blanking width
        en_d = 1'b1;
        cnt_hs = 0; hs_min = 9999; hs_max = -1; cnt_de = 0; cnt_ls = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!hs_d) begin
                cnt_hs++;
                if (int'(hpos_d) < hs_min) hs_min = int'(hpos_d);
                if (int'(hpos_d) > hs_max) hs_max = int'(hpos_d);
            end
            if (!de_d) cnt_de++;
            if (ls_d) cnt_ls++;
        end
        chk("line.hs_cnt", cnt_hs, 96);  chk("line.hs_min", hs_min, 656);
        chk("line.hs_max", hs_max, 751); chk("line.de_low", cnt_de, 160);
        chk("line.ls_cnt", cnt_ls, 1);
        repeat (800) step();
        chk("line2.vpos", vpos_d, 2);    chk("line2.hpos", hpos_d, 0);

        // Reset mid-line with pix_en held high
        repeat (123) step();
        chk("mid.hpos", hpos_d, 123);
        rst_d = 1'b1;
        step();
        chk("midrst.hpos", hpos_d, 0);   chk("midrst.vpos", vpos_d, 0);
        chk("midrst.fs", fs_d, 0);       chk("midrst.ls", ls_d, 0);
        chk("midrst.hsync", hs_d, 1);    chk("midrst.de", de_d, 1);
        rst_d = 1'b0;

        // Small config: five frames at full rate
        rst_s = 1'b1; step(); rst_s = 1'b0; en_s = 1'b1;
        cnt_vs = 0; cnt_hs = 0; cnt_vbs = 0; nfs = 0;
        for (int i = 0; i < 240; i++) begin
            step();
            if (vs_s) cnt_vs++;
            if (hs_s) cnt_hs++;
            if (vbs_s) cnt_vbs++;
            if (vbs_s && !ls_s) cnt_vbs += 100;
            if (fs_s && nfs < 5) begin
                fcseq[nfs] = int'(fc_s);
                nfs++;
            end
        end
        chk("small.vs_cnt", cnt_vs, 40);  chk("small.hs_cnt", cnt_hs, 60);
        chk("small.vbs_cnt", cnt_vbs, 5); chk("small.nfs", nfs, 5);
        chk("small.fc0", fcseq[0], 1);    chk("small.fc1", fcseq[1], 2);
        chk("small.fc2", fcseq[2], 3);    chk("small.fc3", fcseq[3], 0);
        chk("small.fc4", fcseq[4], 1);

        // 1-of-4 enable: frame period and strobe width
        rst_s = 1'b1; step(); rst_s = 1'b0;
        t_first = -1; t_second = -1; adj = 0; prev_ls = 1'b0;
        for (int i = 0; i < 500; i++) begin
            en_s = (i % 4 == 0);
            step();
            if (ls_s && prev_ls) adj++;
            prev_ls = ls_s;
            if (fs_s) begin
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
        end
        chk("q.seen", (t_first >= 0 && t_second >= 0) ? 1 : 0, 1);
        chk("q.period", t_second - t_first, 192);
        chk("q.adjacent_ls", adj, 0);

        // Small config reset mid-frame
        en_s = 1'b1;
        repeat (13) step();
        rst_s = 1'b1;
        step();
        chk("srst.hpos", hpos_s, 0);  chk("srst.vpos", vpos_s, 0);
        chk("srst.fs", fs_s, 0);      chk("srst.fc", fc_s, 0);
        chk("srst.hsync", hs_s, 0);   chk("srst.vsync", vs_s, 0);
        rst_s = 1'b0;

        // Random enables with occasional resets; model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            en_d  = 1'($urandom_range(0, 1));
            en_s  = ($urandom_range(0, 2) != 0);
            rst_d = ($urandom_range(0, 299) == 0);
            rst_s = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_d = 1'b0; rst_s = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
